mem_burst_seq: RTL and testbench
================================

Name: mem_burst_seq

Overview:
- Processor-side initiator for the 32x16 data memory: sequences load-multiple / store-multiple (LM/SM) transfers.
- Walks an 8-bit register mask from a base address and drives the memory's active-low read/write strobes, address and write data.
- Returns read data to the register file.
- Sits between the multicycle control FSM (start/done) and the memory port.

Parameters:
- AW, 5, memory address width (32 words)
- DW, 16, data word width
- NREG, 8, register count; mask width; register index width is log2(NREG) = 3

Ports:
- clk  in  1  system clock; block logic on posedge
- proc_rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request from control FSM; sampled only in IDLE
- is_store  in  1  1 = SM (reg->mem), 0 = LM (mem->reg); captured at start
- base_addr  in  AW  first memory word address; captured at start
- reg_mask  in  NREG  bit i set = transfer register i; captured at start
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- mem_addr  out  AW  memory address
- mem_rd_n  out  1  active-low read strobe
- mem_wr_n  out  1  active-low write strobe
- mem_wdata  out  DW  store data
- mem_rdata  in  DW  memory read data, valid at the posedge after the strobed negedge
- rf_raddr  out  3  register-file read index (stores)
- rf_rdata  in  DW  register-file read data, combinational from rf_raddr
- rf_waddr  out  3  register-file write index (loads)
- rf_wdata  out  DW  register-file write data
- rf_we  out  1  register-file write enable, one cycle per loaded word

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; busy = 0; done = 0; rf_we = 0.
  - mem_rd_n = 1; mem_wr_n = 1.
  - mem_addr = 0; mem_wdata = 0; rf_raddr = 0; rf_waddr = 0; rf_wdata = 0.
  - Reset mid-transfer aborts it; memory strobes deassert the same instant; no done pulse.
- Strobe timing: all memory-side outputs are registered on posedge, so they are stable across the negedge at which the memory samples.
- Strobe exclusivity: mem_rd_n and mem_wr_n are never low together. Both are high in every cycle outside ACCESS.
- States: IDLE, ACCESS, CAPTURE, FIN.
- IDLE:
  - On start = 1, capture is_store, base_addr and reg_mask into ptr/mask registers.
  - Empty mask -> FIN. Otherwise -> ACCESS.
- ACCESS (word handling):
  - cur = lowest set bit of the remaining mask.
  - Drive mem_addr = ptr.
  - Store: drive mem_wr_n = 0 and mem_wdata = rf_rdata with rf_raddr = cur.
  - Load: drive mem_rd_n = 0.
- ACCESS (sequencing):
  - Store: clear the mask bit and increment ptr. Next state is ACCESS if bits remain, else FIN.
  - Load: next state is CAPTURE.
- CAPTURE (loads only):
  - Strobes high.
  - Register mem_rdata into rf_wdata; set rf_waddr = cur; rf_we = 1 for exactly this cycle.
  - Clear the mask bit and increment ptr. Next state is ACCESS if bits remain, else FIN.
- FIN: done = 1 for one cycle, busy = 0; return to IDLE.
- Latency:
  - Store: 1 cycle per word.
  - Load: 2 cycles per word.
  - From start to done pulse: popcount + 1 cycles (store), 2*popcount + 1 cycles (load).
  - Empty mask: done 2 cycles after start; no memory strobe, no rf_we.
- Order: ascending register index; each successive word uses ptr+1.
- Address wrap: ptr is AW-bit modulo; 31 -> 0 wraps silently.
- start while busy or in FIN: ignored; the captured parameters are not disturbed.

Optional Feature:
- Macro MEM_BURST_SEQ_WRAP_ERR_EN.
- When defined:
  - Adds output wrap_err (1 bit), reset 0.
  - wrap_err is set when ptr increments from 31 to 0 while mask bits remain.
  - It stays sticky until the next accepted start clears it; the transfer still completes normally.
- When undefined: port absent, wrap is silent; all other behaviour is identical.

Decomposition:
- Shared package: AW/DW/NREG constants and state encoding (IDLE = 2'd0, ACCESS = 2'd1, CAPTURE = 2'd2, FIN = 2'd3).
- One sub-module, prio_enc8: combinational lowest-set-bit encoder. Outputs a 3-bit index plus a none flag; reused by the main FSM.

Test Plan:
- Store burst: mask = 8'b0000_0101, base = 5'd4, rf R0 = 16'hAAAA, R2 = 16'h5555.
  - mem[4] = AAAA, mem[5] = 5555.
  - Exactly 2 cycles with mem_wr_n = 0; done at cycle 3 after start.
- Load burst: mask = 8'b1000_0010, base = 5'd10, mem[10] = 16'h1234, mem[11] = 16'hBEEF.
  - rf_we pulses twice: R1 = 1234, then R7 = BEEF.
  - done at cycle 5 after start.
- Empty mask: start with mask = 0.
  - No strobe low, no rf_we; done 2 cycles after start.
- Wrap: store with mask = 8'hFF, base = 5'd30.
  - Writes go to addresses 30, 31, 0..5.
  - With MEM_BURST_SEQ_WRAP_ERR_EN, wrap_err = 1 from the third word onward.
- Reset mid-load: assert proc_rst during the second CAPTURE of a 4-word load.
  - Strobes high and rf_we = 0 immediately; state IDLE; no done pulse.
  - A fresh start after reset release completes normally.
- start held high through a 3-word store: only one transfer occurs, and captured base/mask are unchanged mid-burst.

Source files
------------

// File: rtl/mem_burst_seq_pkg.sv
// Shared constants and FSM state encoding for the LM/SM burst sequencer.
package mem_burst_seq_pkg;

    localparam int AW   = 5;
    localparam int DW   = 16;
    localparam int NREG = 8;
    localparam int IW   = $clog2(NREG);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        FIN     = 2'd3
    } state_t;

    function automatic logic [NREG-1:0] bit_of(input logic [IW-1:0] idx);
        return {{(NREG-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/mem_burst_seq_prio.sv
// Lowest-set-bit encoder for the 8-bit register mask; none = 1 when the mask is empty.
module prio_enc8
    import mem_burst_seq_pkg::*;
(
    input  logic [NREG-1:0] vec,
    output logic [IW-1:0]   idx,
    output logic            none
);

    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx  = IW'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_burst_seq.sv
// Load/store-multiple burst sequencer between the control FSM and the 32x16 data memory.
// Optional sticky address-wrap flag (output wrap_err) enabled by MEM_BURST_SEQ_WRAP_ERR_EN.
module mem_burst_seq
    import mem_burst_seq_pkg::*;
(
    input  logic            clk,
    input  logic            proc_rst,
    input  logic            start,
    input  logic            is_store,
    input  logic [AW-1:0]   base_addr,
    input  logic [NREG-1:0] reg_mask,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_rd_n,
    output logic            mem_wr_n,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic [IW-1:0]   rf_raddr,
    input  logic [DW-1:0]   rf_rdata,
    output logic [IW-1:0]   rf_waddr,
    output logic [DW-1:0]   rf_wdata,
`ifdef MEM_BURST_SEQ_WRAP_ERR_EN
    output logic            wrap_err,
`endif
    output logic            rf_we
);

    // state   | meaning
    // IDLE    | waiting for start
    // ACCESS  | one memory word strobed (write data or read request)
    // CAPTURE | load only: read data written to the register file
    // FIN     | done pulse (empty mask spends one extra cycle here first)

    state_t          state, state_nx;
    logic [AW-1:0]   ptr, ptr_nx, ptr_inc, addr_nx, launch_addr;
    logic [NREG-1:0] mask, mask_nx, enc_in;
    logic [IW-1:0]   cur, cur_nx, enc_idx, waddr_nx;
    logic [DW-1:0]   wdata_nx, rfw_nx;
    logic            enc_none, store_r, store_nx, hold_r, hold_nx;
    logic            rd_n_nx, wr_n_nx, we_nx, adv, launch, launch_store;

    // mask holds the bits still pending after the word currently in flight
    assign enc_in  = (state == IDLE) ? reg_mask : mask;
    assign ptr_inc = ptr + AW'(1);
    assign adv     = ((state == ACCESS) && store_r) || (state == CAPTURE);

    prio_enc8 u_enc (
        .vec  (enc_in),
        .idx  (enc_idx),
        .none (enc_none)
    );

    assign busy = (state == ACCESS) || (state == CAPTURE) || ((state == FIN) && hold_r);
    assign done = (state == FIN) && !hold_r;

    // Look ahead one word so the store data can be registered on the edge that opens ACCESS
    assign rf_raddr = (!proc_rst && (((state == IDLE) && start) || ((state == ACCESS) && store_r)))
                      ? enc_idx : '0;

    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        mask_nx      = mask;
        cur_nx       = cur;
        store_nx     = store_r;
        hold_nx      = 1'b0;
        addr_nx      = mem_addr;
        rd_n_nx      = 1'b1;
        wr_n_nx      = 1'b1;
        wdata_nx     = mem_wdata;
        we_nx        = 1'b0;
        waddr_nx     = rf_waddr;
        rfw_nx       = rf_wdata;
        launch       = 1'b0;
        launch_addr  = ptr_inc;
        launch_store = store_r;

        case (state)
            IDLE: begin
                if (start) begin
                    store_nx = is_store;
                    ptr_nx   = base_addr;
                    if (enc_none) begin
                        state_nx = FIN;
                        hold_nx  = 1'b1;
                    end else begin
                        launch       = 1'b1;
                        launch_addr  = base_addr;
                        launch_store = is_store;
                    end
                end
            end
            ACCESS: begin
                if (!store_r) begin
                    state_nx = CAPTURE;
                    we_nx    = 1'b1;
                    waddr_nx = cur;
                    rfw_nx   = mem_rdata;
                end
            end
            CAPTURE: ;
            FIN: state_nx = hold_r ? FIN : IDLE;
        endcase

        if (adv) begin
            ptr_nx = ptr_inc;
            if (enc_none) state_nx = FIN;
            else          launch   = 1'b1;
        end

        if (launch) begin
            state_nx = ACCESS;
            cur_nx   = enc_idx;
            mask_nx  = enc_in & ~bit_of(enc_idx);
            addr_nx  = launch_addr;
            if (launch_store) begin
                wr_n_nx  = 1'b0;
                wdata_nx = rf_rdata;
            end else begin
                rd_n_nx  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge proc_rst) begin
        if (proc_rst) begin
            state     <= IDLE;
            ptr       <= '0;
            mask      <= '0;
            cur       <= '0;
            store_r   <= 1'b0;
            hold_r    <= 1'b0;
            mem_addr  <= '0;
            mem_rd_n  <= 1'b1;
            mem_wr_n  <= 1'b1;
            mem_wdata <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            mask      <= mask_nx;
            cur       <= cur_nx;
            store_r   <= store_nx;
            hold_r    <= hold_nx;
            mem_addr  <= addr_nx;
            mem_rd_n  <= rd_n_nx;
            mem_wr_n  <= wr_n_nx;
            mem_wdata <= wdata_nx;
            rf_we     <= we_nx;
            rf_waddr  <= waddr_nx;
            rf_wdata  <= rfw_nx;
        end
    end

`ifdef MEM_BURST_SEQ_WRAP_ERR_EN
    always_ff @(posedge clk or posedge proc_rst) begin
        if (proc_rst)                      wrap_err <= 1'b0;
        else if ((state == IDLE) && start) wrap_err <= 1'b0;
        else if (adv && !enc_none && (&ptr)) wrap_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_mem_burst_seq.sv
// Self-checking bench for mem_burst_seq: vector table, abort/hold sequences, random bursts vs. a word-list model.
module tb_mem_burst_seq;
    import mem_burst_seq_pkg::*;

    logic            clk = 1'b0;
    logic            proc_rst, start, is_store;
    logic [AW-1:0]   base_addr;
    logic [NREG-1:0] reg_mask;
    logic            busy, done, mem_rd_n, mem_wr_n, rf_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata, rf_rdata, rf_wdata;
    logic [IW-1:0]   rf_raddr, rf_waddr;
`ifdef MEM_BURST_SEQ_WRAP_ERR_EN
    logic            wrap_err;
    logic            wrap_q[$];
    logic            exp_wrapw[$];
`endif

    always #5 clk = ~clk;

    mem_burst_seq dut (
        .clk(clk), .proc_rst(proc_rst), .start(start), .is_store(is_store),
        .base_addr(base_addr), .reg_mask(reg_mask), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef MEM_BURST_SEQ_WRAP_ERR_EN
        .wrap_err(wrap_err),
`endif
        .rf_we(rf_we)
    );

    logic [DW-1:0] mem[32], exp_mem[32];
    logic [DW-1:0] rf[8], exp_rf[8];
    assign rf_rdata = rf[rf_raddr];

    int n_cmp = 0, n_bad = 0;
    int wr_cnt, rd_cnt, we_cnt, done_cnt, exp_lat;
    int addr_q[$], exp_addr[$];
    bit exp_wrap;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of the memory / register-file environment, evaluated at the negedge
    task automatic tick();
        @(negedge clk);
        check("strobe_excl", int'(mem_rd_n | mem_wr_n), 1);
        if (!mem_wr_n) begin
            mem[mem_addr] = mem_wdata;
            wr_cnt++;
            addr_q.push_back(int'(mem_addr));
`ifdef MEM_BURST_SEQ_WRAP_ERR_EN
            wrap_q.push_back(wrap_err);
`endif
        end
        if (!mem_rd_n) begin
            mem_rdata = mem[mem_addr];
            rd_cnt++;
            addr_q.push_back(int'(mem_addr));
        end
        if (rf_we) begin
            rf[rf_waddr] = rf_wdata;
            we_cnt++;
        end
        if (done) done_cnt++;
    endtask

    // Reference: list of (register, address) pairs in ascending register order
    task automatic model(input bit st, input logic [AW-1:0] base, input logic [NREG-1:0] mask);
        int  k = 0;
        bit  seen31 = 0;
        logic [AW-1:0] a;
        for (int i = 0; i < 32; i++) exp_mem[i] = mem[i];
        for (int i = 0; i < 8; i++)  exp_rf[i]  = rf[i];
        exp_addr.delete();
        exp_wrap = 0;
`ifdef MEM_BURST_SEQ_WRAP_ERR_EN
        exp_wrapw.delete();
`endif
        for (int i = 0; i < NREG; i++) begin
            if (mask[i]) begin
                a = AW'((int'(base) + k) % 32);
                exp_addr.push_back(int'(a));
`ifdef MEM_BURST_SEQ_WRAP_ERR_EN
                exp_wrapw.push_back(seen31);
`endif
                if (st) exp_mem[a] = rf[i];
                else    exp_rf[i]  = mem[a];
                if (a == AW'(31)) seen31 = 1;
                k++;
            end
        end
        // wrap only counts if a word followed the one at address 31
        for (int j = 0; j < k - 1; j++) if (exp_addr[j] == 31) exp_wrap = 1;
        exp_lat = (k == 0) ? 2 : (st ? k + 1 : 2 * k + 1);
    endtask

    task automatic run_burst(input bit st, input logic [AW-1:0] base, input logic [NREG-1:0] mask,
                             input bit hold, output int lat, output int nwr, output int nrd, output int nwe);
        int bad;
        model(st, base, mask);
        wr_cnt = 0; rd_cnt = 0; we_cnt = 0; done_cnt = 0;
        addr_q.delete();
`ifdef MEM_BURST_SEQ_WRAP_ERR_EN
        wrap_q.delete();
`endif
        start = 1'b1; is_store = st; base_addr = base; reg_mask = mask;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 1) check("busy_after_start", int'(busy), 1);
            if (!hold) start = 1'b0;
            if (hold && k == 2) begin
                base_addr = 5'd20;
                reg_mask  = 8'hF0;
                is_store  = ~st;
            end
            if (done) begin
                lat = k;
                start = 1'b0;
                break;
            end
        end
        tick();
        check("latency", lat, exp_lat);
        check("done_pulses", done_cnt, 1);
        check("busy_end", int'(busy), 0);
        check("addr_count", addr_q.size(), exp_addr.size());
        bad = 0;
        for (int j = 0; j < addr_q.size() && j < exp_addr.size(); j++)
            if (addr_q[j] != exp_addr[j]) bad++;
        check("addr_order", bad, 0);
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== exp_mem[i]) bad++;
        check("mem_contents", bad, 0);
        bad = 0;
        for (int i = 0; i < 8; i++) if (rf[i] !== exp_rf[i]) bad++;
        check("rf_contents", bad, 0);
`ifdef MEM_BURST_SEQ_WRAP_ERR_EN
        check("wrap_err_final", int'(wrap_err), int'(exp_wrap));
        if (st) begin
            bad = 0;
            for (int j = 0; j < wrap_q.size() && j < exp_wrapw.size(); j++)
                if (wrap_q[j] !== exp_wrapw[j]) bad++;
            check("wrap_err_per_word", bad, 0);
        end
`endif
        nwr = wr_cnt; nrd = rd_cnt; nwe = we_cnt;
    endtask

    typedef struct {
        bit            st;
        logic [AW-1:0] base;
        logic [7:0]    mask;
        bit            hold;
        int            lat, nwr, nrd, nwe;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat, nwr, nrd, nwe;
        vecs[0] = '{1'b1, 5'd4,  8'h05, 1'b0, 3,  2, 0, 0};
        vecs[1] = '{1'b0, 5'd10, 8'h82, 1'b0, 5,  0, 2, 2};
        vecs[2] = '{1'b1, 5'd7,  8'h00, 1'b0, 2,  0, 0, 0};
        vecs[3] = '{1'b0, 5'd3,  8'h00, 1'b0, 2,  0, 0, 0};
        vecs[4] = '{1'b1, 5'd30, 8'hFF, 1'b0, 9,  8, 0, 0};
        vecs[5] = '{1'b0, 5'd31, 8'h81, 1'b0, 5,  0, 2, 2};
        vecs[6] = '{1'b1, 5'd0,  8'h80, 1'b0, 2,  1, 0, 0};
        vecs[7] = '{1'b0, 5'd0,  8'hFF, 1'b0, 17, 0, 8, 8};
        vecs[8] = '{1'b1, 5'd8,  8'h07, 1'b1, 4,  3, 0, 0};

        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 8; i++)  rf[i]  = 16'($urandom);
        mem_rdata = '0;
        start = 1'b0; is_store = 1'b0; base_addr = '0; reg_mask = '0;
        proc_rst = 1'b0;
        #1 proc_rst = 1'b1;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rf_we", int'(rf_we), 0);
        check("rst_rd_n", int'(mem_rd_n), 1);
        check("rst_wr_n", int'(mem_wr_n), 1);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_mem_wdata", int'(mem_wdata), 0);
        check("rst_rf_raddr", int'(rf_raddr), 0);
        check("rst_rf_waddr", int'(rf_waddr), 0);
        check("rst_rf_wdata", int'(rf_wdata), 0);
        tick(); tick();
        proc_rst = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            if (v == 0) begin rf[0] = 16'hAAAA; rf[2] = 16'h5555; end
            if (v == 1) begin mem[10] = 16'h1234; mem[11] = 16'hBEEF; end
            run_burst(vecs[v].st, vecs[v].base, vecs[v].mask, vecs[v].hold, lat, nwr, nrd, nwe);
            check($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
            check($sformatf("vec%0d_wr_strobes", v), nwr, vecs[v].nwr);
            check($sformatf("vec%0d_rd_strobes", v), nrd, vecs[v].nrd);
            check($sformatf("vec%0d_rf_we", v), nwe, vecs[v].nwe);
            if (v == 0) begin
                check("store_mem4", int'(mem[4]), 32'hAAAA);
                check("store_mem5", int'(mem[5]), 32'h5555);
            end
            if (v == 1) begin
                check("load_r1", int'(rf[1]), 32'h1234);
                check("load_r7", int'(rf[7]), 32'hBEEF);
            end
            tick();
        end

        // Reset during the second CAPTURE of a 4-word load
        start = 1'b1; is_store = 1'b0; base_addr = 5'd12; reg_mask = 8'h0F;
        done_cnt = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            start = 1'b0;
        end
        check("abort_pre_we", int'(rf_we), 1);
        proc_rst = 1'b1;
        #1;
        check("abort_rd_n", int'(mem_rd_n), 1);
        check("abort_wr_n", int'(mem_wr_n), 1);
        check("abort_rf_we", int'(rf_we), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        tick(); tick(); tick();
        check("abort_no_done", done_cnt, 0);
        proc_rst = 1'b0;
        tick();
        run_burst(1'b1, 5'd16, 8'h5A, 1'b0, lat, nwr, nrd, nwe);
        check("post_abort_wr", nwr, 4);

        for (int r = 0; r < 24; r++) begin
            if (r % 4 == 0) for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
            run_burst(1'($urandom_range(0, 1)), AW'($urandom), NREG'($urandom), 1'b0, lat, nwr, nrd, nwe);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
